pc_fetch_ctrl: RTL and testbench

Fetch sequencer that owns the architectural PC register and drives the instruction-memory port so the core tolerates multi-cycle instruction memory. It sits between the NPC next-PC logic and the instruction memory. It presents one instruction at a time to decode and advances the PC to the NPC result only when that instruction commits. It also traps misaligned next-PC values and memory timeouts.

---
 rtl/pc_fetch_ctrl_pkg.sv | 18 +
 rtl/pc_fetch_ctrl_wdog.sv | 30 +++
 rtl/pc_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencer: FSM states and error causes.
package pc_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_VALID = 3'd3,
        FS_ERR   = 3'd4
    } fstate_e;

    typedef enum logic [1:0] {
        FERR_NONE     = 2'b00,
        FERR_MISALIGN = 2'b01,
        FERR_TIMEOUT  = 2'b10
    } ferr_e;

endpackage

// File: rtl/pc_fetch_ctrl_wdog.sv
// Response watchdog: 16-bit cycle counter with a terminal-count flag at WAIT_MAX-1.
module fetch_wdog
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [15:0] TC_VAL = 16'(WAIT_MAX - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 16'd1;
    end

    // tc marks the last allowed wait cycle; the FSM times out on this edge.
    assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request per instruction, holds it for decode until commit.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_i,
    input  logic        commit,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid,
    output logic        fetch_err,
    output logic [1:0]  err_cause,
    input  logic        err_clr
);

    fstate_e state;
    logic    wd_clr, wd_en, wd_tc;

    // Timer runs only in WAIT and restarts from zero on every entry.
    assign wd_en  = (state == FS_WAIT);
    assign wd_clr = ~wd_en;

    fetch_wdog #(.WAIT_MAX(WAIT_MAX)) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (wd_clr),
        .en  (wd_en),
        .tc  (wd_tc)
    );

    assign imem_addr = pc_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FS_IDLE;
            pc_o       <= RESET_PC;
            inst_o     <= '0;
            inst_valid <= 1'b0;
            imem_req   <= 1'b0;
            fetch_err  <= 1'b0;
            err_cause  <= FERR_NONE;
        end else begin
            case (state)
                FS_IDLE: begin
                    state    <= FS_REQ;
                    imem_req <= 1'b1;
                end
                FS_REQ: begin
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        if (imem_rvalid) begin
                            inst_o     <= imem_rdata;
                            inst_valid <= 1'b1;
                            state      <= FS_VALID;
                        end else begin
                            state <= FS_WAIT;
                        end
                    end
                end
                FS_WAIT: begin
                    // A response on the terminal cycle still counts.
                    if (imem_rvalid) begin
                        inst_o     <= imem_rdata;
                        inst_valid <= 1'b1;
                        state      <= FS_VALID;
                    end else if (wd_tc) begin
                        fetch_err <= 1'b1;
                        err_cause <= FERR_TIMEOUT;
                        state     <= FS_ERR;
                    end
                end
                FS_VALID: begin
                    if (commit && !stall) begin
                        inst_valid <= 1'b0;
                        if (npc_i[1:0] == 2'b00) begin
                            pc_o     <= npc_i;
                            imem_req <= 1'b1;
                            state    <= FS_REQ;
                        end else begin
                            fetch_err <= 1'b1;
                            err_cause <= FERR_MISALIGN;
                            state     <= FS_ERR;
                        end
                    end
                end
                FS_ERR: begin
                    if (err_clr) begin
                        pc_o      <= RESET_PC;
                        fetch_err <= 1'b0;
                        err_cause <= FERR_NONE;
                        state     <= FS_IDLE;
                    end
                end
                default: begin
                    state      <= FS_IDLE;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: vector table plus hand sequences, checked through an expected-value queue.
module tb_pc_fetch_ctrl;

    localparam int WMAX = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc_i = '0;
    logic        commit = 1'b0, stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc_o, inst_o;
    logic        inst_valid, fetch_err;
    logic [1:0]  err_cause;
    logic        err_clr = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .npc_i(npc_i), .commit(commit), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc_o(pc_o),
        .inst_o(inst_o), .inst_valid(inst_valid), .fetch_err(fetch_err),
        .err_cause(err_cause), .err_clr(err_clr)
    );

    typedef struct packed {
        logic        rst, commit, stall, gnt, rvalid, err_clr;
        logic [31:0] rdata, npc;
    } in_t;

    typedef struct packed {
        logic        req;
        logic [31:0] pc, inst;
        logic        ivld, ferr;
        logic [1:0]  cause;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    vec_t  tbl[16];

    function automatic in_t vi(logic r, logic c, logic s, logic g, logic v, logic ec,
                               logic [31:0] rd, logic [31:0] np);
        in_t t;
        t.rst = r; t.commit = c; t.stall = s; t.gnt = g; t.rvalid = v; t.err_clr = ec;
        t.rdata = rd; t.npc = np;
        return t;
    endfunction

    function automatic exp_t ve(logic rq, logic [31:0] p, logic [31:0] ins,
                                logic iv, logic fe, logic [1:0] ca);
        exp_t t;
        t.req = rq; t.pc = p; t.inst = ins; t.ivld = iv; t.ferr = fe; t.cause = ca;
        return t;
    endfunction

    task automatic drive(input in_t v);
        rst = v.rst; commit = v.commit; stall = v.stall; imem_gnt = v.gnt;
        imem_rvalid = v.rvalid; err_clr = v.err_clr; imem_rdata = v.rdata; npc_i = v.npc;
    endtask

    task automatic check_one();
        exp_t  e;
        string nm;
        logic  ok;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        ok = (imem_req === e.req) && (pc_o === e.pc) && (inst_o === e.inst) &&
             (inst_valid === e.ivld) && (fetch_err === e.ferr) && (err_cause === e.cause) &&
             (!e.req || imem_addr === e.pc);
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h pc=%h inst=%h vld=%b err=%b cause=%b, want req=%b addr=%h pc=%h inst=%h vld=%b err=%b cause=%b",
                     nm, imem_req, imem_addr, pc_o, inst_o, inst_valid, fetch_err, err_cause,
                     e.req, e.pc, e.pc, e.inst, e.ivld, e.ferr, e.cause);
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next edge, then check.
    task automatic cyc(input in_t v, input exp_t e, input string nm);
        drive(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        tbl[0]  = '{vi(0,0,0,1,1,0,32'h13,0),          ve(1,32'h0,32'h0,0,0,0)};
        tbl[1]  = '{vi(0,0,0,1,1,0,32'h13,0),          ve(0,32'h0,32'h13,1,0,0)};
        tbl[2]  = '{vi(0,1,1,0,0,0,0,32'h4),           ve(0,32'h0,32'h13,1,0,0)};
        tbl[3]  = '{vi(0,1,1,0,0,0,0,32'h4),           ve(0,32'h0,32'h13,1,0,0)};
        tbl[4]  = '{vi(0,1,1,0,0,0,0,32'h4),           ve(0,32'h0,32'h13,1,0,0)};
        tbl[5]  = '{vi(0,1,0,0,0,0,0,32'h4),           ve(1,32'h4,32'h13,0,0,0)};
        tbl[6]  = '{vi(0,0,0,0,0,0,0,0),               ve(1,32'h4,32'h13,0,0,0)};
        tbl[7]  = '{vi(0,0,0,1,1,0,32'h0010_0093,0),   ve(0,32'h4,32'h0010_0093,1,0,0)};
        tbl[8]  = '{vi(0,1,0,0,0,0,0,32'hFFFF_FFFC),   ve(1,32'hFFFF_FFFC,32'h0010_0093,0,0,0)};
        tbl[9]  = '{vi(0,0,0,1,0,0,0,0),               ve(0,32'hFFFF_FFFC,32'h0010_0093,0,0,0)};
        tbl[10] = '{vi(0,0,0,0,1,0,32'hAAAA,0),        ve(0,32'hFFFF_FFFC,32'hAAAA,1,0,0)};
        tbl[11] = '{vi(0,0,0,0,1,0,32'hBBBB,0),        ve(0,32'hFFFF_FFFC,32'hAAAA,1,0,0)};
        tbl[12] = '{vi(0,1,0,0,0,0,0,32'h102),         ve(0,32'hFFFF_FFFC,32'hAAAA,0,1,2'b01)};
        tbl[13] = '{vi(0,1,0,0,1,0,32'hCCCC,32'h8),    ve(0,32'hFFFF_FFFC,32'hAAAA,0,1,2'b01)};
        tbl[14] = '{vi(0,0,0,0,0,1,0,0),               ve(0,32'h0,32'hAAAA,0,0,0)};
        tbl[15] = '{vi(0,0,0,0,0,0,0,0),               ve(1,32'h0,32'hAAAA,0,0,0)};

        // Reset state
        drive(vi(1,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(ve(0,32'h0,32'h0,0,0,0));
        name_q.push_back("reset_state");
        check_one();

        for (int i = 0; i < 16; i++)
            cyc(tbl[i].i, tbl[i].e, $sformatf("vec%0d", i));

        // Late grant (commit in REQ ignored), then rvalid 10 cycles after grant
        for (int k = 0; k < 4; k++)
            cyc(vi(0,1,0,0,0,0,0,32'h40), ve(1,32'h0,32'hAAAA,0,0,0), $sformatf("gnt_late%0d", k));
        cyc(vi(0,0,0,1,0,0,0,0), ve(0,32'h0,32'hAAAA,0,0,0), "gnt_to_wait");
        for (int k = 1; k < 10; k++)
            cyc(vi(0,0,0,0,0,0,0,0), ve(0,32'h0,32'hAAAA,0,0,0), $sformatf("wait_a%0d", k));
        cyc(vi(0,0,0,0,1,0,32'h1234,0), ve(0,32'h0,32'h1234,1,0,0), "rvalid_late");

        // rvalid on the terminal wait cycle wins over the timeout
        cyc(vi(0,1,0,0,0,0,0,32'h10), ve(1,32'h10,32'h1234,0,0,0), "commit_10");
        cyc(vi(0,0,0,1,0,0,0,0), ve(0,32'h10,32'h1234,0,0,0), "gnt_b");
        for (int k = 1; k < WMAX; k++)
            cyc(vi(0,0,0,0,0,0,0,0), ve(0,32'h10,32'h1234,0,0,0), $sformatf("wait_b%0d", k));
        cyc(vi(0,0,0,0,1,0,32'h5678,0), ve(0,32'h10,32'h5678,1,0,0), "rvalid_at_tc");

        // Timeout after WMAX wait cycles, then recovery through err_clr
        cyc(vi(0,1,0,0,0,0,0,32'h20), ve(1,32'h20,32'h5678,0,0,0), "commit_20");
        cyc(vi(0,0,0,1,0,0,0,0), ve(0,32'h20,32'h5678,0,0,0), "gnt_c");
        for (int k = 1; k < WMAX; k++)
            cyc(vi(0,0,0,0,0,0,0,0), ve(0,32'h20,32'h5678,0,0,0), $sformatf("wait_c%0d", k));
        cyc(vi(0,0,0,0,0,0,0,0), ve(0,32'h20,32'h5678,0,1,2'b10), "timeout");
        cyc(vi(0,1,0,0,1,0,32'h9999,32'h24), ve(0,32'h20,32'h5678,0,1,2'b10), "err_hold");
        cyc(vi(0,0,0,0,0,1,0,0), ve(0,32'h0,32'h5678,0,0,0), "err_clr_c");
        cyc(vi(0,0,0,0,0,0,0,0), ve(1,32'h0,32'h5678,0,0,0), "refetch_c");

        // Reset in WAIT, stray rvalid during reset and in IDLE
        cyc(vi(0,0,0,1,0,0,0,0), ve(0,32'h0,32'h5678,0,0,0), "gnt_d");
        cyc(vi(0,0,0,0,0,0,0,0), ve(0,32'h0,32'h5678,0,0,0), "wait_d1");
        cyc(vi(0,0,0,0,0,0,0,0), ve(0,32'h0,32'h5678,0,0,0), "wait_d2");
        drive(vi(1,0,0,0,0,0,0,0));
        exp_q.push_back(ve(0,32'h0,32'h0,0,0,0));
        name_q.push_back("async_reset");
        #2;
        check_one();
        cyc(vi(1,0,0,0,1,0,32'hDEAD,0), ve(0,32'h0,32'h0,0,0,0), "rvalid_in_reset");
        cyc(vi(0,0,0,0,1,0,32'hBEEF,0), ve(1,32'h0,32'h0,0,0,0), "rvalid_in_idle");
        cyc(vi(0,0,0,0,0,0,0,0), ve(1,32'h0,32'h0,0,0,0), "post_reset_req");

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: %0d expected entries left unchecked", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
